store_write_buffer: RTL and testbench

STORE_WRITE_BUFFER -- requirements
Module: store_write_buffer

---
 rtl/store_write_buffer.sv | 165 ++++++++++++++++
 tb/tb_store_write_buffer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/store_write_buffer.sv
// Word-granular store write buffer: committed stores enter a circular FIFO and drain one at a time to memory.
// Optional feature: define WB_COALESCE_EN to merge same-word stores into the youngest unlocked entry.
`ifndef NUM_SQ_DCACHE
`define NUM_SQ_DCACHE 2
`endif

module store_write_buffer #(
  parameter int WB_DEPTH = 4,
  parameter int NUM_IN   = `NUM_SQ_DCACHE
) (
  input  logic                        clock,
  input  logic                        reset,
  // Per slot, MSB first: {valid, addr[31:0], sign_size[2:0], data[31:0]}; sign_size = {sign, size}, size 00=BYTE 01=HALF 10=WORD
  input  logic [NUM_IN*68-1:0]        sq_dcache_packet,
  output logic [NUM_IN-1:0]           dcache_accept,
  output logic                        mem_req_valid,
  output logic [31:0]                 mem_req_addr,
  output logic [31:0]                 mem_req_data,
  output logic [3:0]                  mem_req_byte_en,
  input  logic                        mem_req_ready,
  input  logic                        mem_ack,
  output logic                        empty,
  output logic [$clog2(WB_DEPTH):0]   count,
  output logic [1:0]                  drain_state
);

  localparam int PKT_W = 68;
  localparam int PW    = $clog2(WB_DEPTH);
  localparam int CW    = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(WB_DEPTH);

  // Handshake: a request transfers on a cycle where mem_req_valid && mem_req_ready; mem_ack later marks it written.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT_ACK = 2'd2} state_t;

  state_t          state_q, state_n;
  logic [29:0]     ent_addr_q [WB_DEPTH];
  logic [31:0]     ent_data_q [WB_DEPTH];
  logic [3:0]      ent_be_q   [WB_DEPTH];
  logic [29:0]     ent_addr_n [WB_DEPTH];
  logic [31:0]     ent_data_n [WB_DEPTH];
  logic [3:0]      ent_be_n   [WB_DEPTH];
  logic [PW-1:0]   head_q, tail_q, tail_n;
  logic [CW-1:0]   count_q, allocs, free_slots;
  logic            retire, chain_ok, alloc;
  logic [PKT_W-1:0] pkt;
  logic [3:0]      lane_be;
  logic [31:0]     lane_data;
  logic [NUM_IN-1:0] unused_sign;
`ifdef WB_COALESCE_EN
  logic            young_valid, merge;
`endif

  function automatic void map_lanes(input logic [1:0] off, input logic [1:0] size,
                                    input logic [31:0] d, output logic [3:0] be,
                                    output logic [31:0] sd);
    case (size)
      2'b00: begin
        be = 4'b0001 << off;
        sd = {24'b0, d[7:0]} << {off, 3'b000};
      end
      2'b01: begin
        be = off[1] ? 4'b1100 : 4'b0011;
        sd = {16'b0, d[15:0]} << {off[1], 4'b0000};
      end
      default: begin
        be = 4'b1111;
        sd = d;
      end
    endcase
  endfunction

  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE:     if (count_q != '0) state_n = S_REQ;
      S_REQ:      if (mem_req_ready) state_n = S_WAIT_ACK;
      S_WAIT_ACK: if (mem_ack) state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  assign retire          = (state_q == S_WAIT_ACK) && mem_ack;
  assign mem_req_valid   = (state_q == S_REQ);
  assign mem_req_addr    = mem_req_valid ? {ent_addr_q[head_q], 2'b00} : 32'h0;
  assign mem_req_data    = mem_req_valid ? ent_data_q[head_q] : 32'h0;
  assign mem_req_byte_en = mem_req_valid ? ent_be_q[head_q] : 4'h0;
  assign empty           = (count_q == '0) && (state_q == S_IDLE);
  assign count           = count_q;
  assign drain_state     = state_q;

  // Slots are walked in order; free space comes only from the start-of-cycle count.
  always_comb begin
    ent_addr_n    = ent_addr_q;
    ent_data_n    = ent_data_q;
    ent_be_n      = ent_be_q;
    tail_n        = tail_q;
    allocs        = '0;
    free_slots    = DEPTH_C - count_q;
    chain_ok      = reset;
    dcache_accept = '0;
    pkt           = '0;
    lane_be       = '0;
    lane_data     = '0;
    alloc         = 1'b0;
    unused_sign   = '0;
`ifdef WB_COALESCE_EN
    young_valid   = (count_q != '0) &&
                    !(((tail_q - 1'b1) == head_q) && (state_q != S_IDLE));
    merge         = 1'b0;
`endif
    for (int i = 0; i < NUM_IN; i++) begin
      pkt            = sq_dcache_packet[i*PKT_W +: PKT_W];
      unused_sign[i] = pkt[34];
      map_lanes(pkt[36:35], pkt[33:32], pkt[31:0], lane_be, lane_data);
      alloc = chain_ok && pkt[67] && (allocs < free_slots);
`ifdef WB_COALESCE_EN
      merge = chain_ok && pkt[67] && young_valid &&
              (ent_addr_n[tail_n - 1'b1] == pkt[66:37]);
      if (merge) begin
        alloc = 1'b0;
        for (int b = 0; b < 4; b++)
          if (lane_be[b]) ent_data_n[tail_n - 1'b1][b*8 +: 8] = lane_data[b*8 +: 8];
        ent_be_n[tail_n - 1'b1] = ent_be_n[tail_n - 1'b1] | lane_be;
      end
      dcache_accept[i] = alloc || merge;
`else
      dcache_accept[i] = alloc;
`endif
      if (alloc) begin
        ent_addr_n[tail_n] = pkt[66:37];
        ent_data_n[tail_n] = lane_data;
        ent_be_n[tail_n]   = lane_be;
        tail_n             = tail_n + 1'b1;
        allocs             = allocs + 1'b1;
      end
`ifdef WB_COALESCE_EN
      if (alloc) young_valid = 1'b1;
`endif
      chain_ok = dcache_accept[i];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int e = 0; e < WB_DEPTH; e++) begin
        ent_addr_q[e] <= '0;
        ent_data_q[e] <= '0;
        ent_be_q[e]   <= '0;
      end
    end else begin
      state_q    <= state_n;
      tail_q     <= tail_n;
      ent_addr_q <= ent_addr_n;
      ent_data_q <= ent_data_n;
      ent_be_q   <= ent_be_n;
      if (retire) head_q <= head_q + 1'b1;
      count_q    <= count_q + allocs - {{(CW-1){1'b0}}, retire};
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer: reset, lane mapping, stalls, full buffer, partial accept, reset abort.
module tb_store_write_buffer;

  localparam int NIN = 2;
  localparam logic [2:0] SZ_BYTE = 3'b000;
  localparam logic [2:0] SZ_HALF = 3'b001;
  localparam logic [2:0] SZ_WORD = 3'b010;

  logic              clock = 1'b0;
  logic              reset;
  logic [NIN*68-1:0] pkts;
  logic [NIN-1:0]    accept;
  logic              req_valid, req_ready, ack, empty;
  logic [31:0]       req_addr, req_data;
  logic [3:0]        req_be;
  logic [2:0]        count;
  logic [1:0]        drain_state;
  int                n_checks = 0;
  int                n_fail = 0;

  store_write_buffer #(.WB_DEPTH(4), .NUM_IN(NIN)) dut (
    .clock(clock), .reset(reset), .sq_dcache_packet(pkts), .dcache_accept(accept),
    .mem_req_valid(req_valid), .mem_req_addr(req_addr), .mem_req_data(req_data),
    .mem_req_byte_en(req_be), .mem_req_ready(req_ready), .mem_ack(ack),
    .empty(empty), .count(count), .drain_state(drain_state)
  );

  always #5 clock = ~clock;

  function automatic logic [67:0] mk(input logic v, input logic [31:0] a,
                                      input logic [2:0] ss, input logic [31:0] d);
    return {v, a, ss, d};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b0; pkts = '0; req_ready = 1'b0; ack = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    check("rst_valid", 32'(req_valid), 32'd0);
    check("rst_addr", req_addr, 32'h0);
    check("rst_data", req_data, 32'h0);
    check("rst_be", 32'(req_be), 32'h0);
    check("rst_accept", 32'(accept), 32'h0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_count", 32'(count), 32'd0);

    // Single word store drains through REQ and WAIT_ACK
    req_ready = 1'b1;
    pkts = {mk(1'b0, 32'h0, SZ_WORD, 32'h0), mk(1'b1, 32'h100, SZ_WORD, 32'hDEADBEEF)};
    #1 check("word_accept", 32'(accept), 32'h1);
    step(); pkts = '0;
    check("word_count", 32'(count), 32'd1);
    step();
    check("word_valid", 32'(req_valid), 32'd1);
    check("word_addr", req_addr, 32'h100);
    check("word_data", req_data, 32'hDEADBEEF);
    check("word_be", 32'(req_be), 32'hF);
    step();
    check("word_wait_valid", 32'(req_valid), 32'd0);
    ack = 1'b1; step(); ack = 1'b0;
    check("word_empty", 32'(empty), 32'd1);
    check("word_count0", 32'(count), 32'd0);

    // Byte and half lane mapping, two slots accepted together
    req_ready = 1'b0;
    pkts = {mk(1'b1, 32'h202, SZ_HALF, 32'h0000_1234), mk(1'b1, 32'h203, SZ_BYTE, 32'h0000_00AB)};
    #1 check("bh_accept", 32'(accept), 32'h3);
    step(); pkts = '0;
    check("bh_count", 32'(count), 32'd2);
    step();
    check("byte_valid", 32'(req_valid), 32'd1);
    check("byte_addr", req_addr, 32'h200);
    check("byte_be", 32'(req_be), 32'h8);
    check("byte_data", req_data, 32'hAB00_0000);

    // Stall with ready low while filling to capacity
    pkts = {mk(1'b1, 32'h404, SZ_WORD, 32'h2222_2222), mk(1'b1, 32'h400, SZ_WORD, 32'h1111_1111)};
    #1 check("fill_accept", 32'(accept), 32'h3);
    for (int k = 0; k < 5; k++) begin
      step();
      pkts = {mk(1'b1, 32'h504, SZ_WORD, 32'h4444_4444), mk(1'b1, 32'h500, SZ_WORD, 32'h3333_3333)};
      check("stall_valid", 32'(req_valid), 32'd1);
      check("stall_addr", req_addr, 32'h200);
      check("stall_be", 32'(req_be), 32'h8);
      check("stall_data", req_data, 32'hAB00_0000);
      #1 check("full_accept", 32'(accept), 32'h0);
    end
    check("full_count", 32'(count), 32'd4);
    req_ready = 1'b1;
    step();
    check("full_wait_valid", 32'(req_valid), 32'd0);
    ack = 1'b1;
    #1 check("ack_same_cycle_accept", 32'(accept), 32'h0);
    step(); ack = 1'b0;
    #1 check("after_ack_accept", 32'(accept), 32'h1);
    check("after_ack_count", 32'(count), 32'd3);
    step(); pkts = '0;
    check("refill_count", 32'(count), 32'd4);
    check("half_valid", 32'(req_valid), 32'd1);
    check("half_addr", req_addr, 32'h200);
    check("half_be", 32'(req_be), 32'hC);
    check("half_data", req_data, 32'h1234_0000);
    step();
    check("half_wait_valid", 32'(req_valid), 32'd0);

    // Reset in WAIT_ACK abandons the transaction; a late ack is ignored
    reset = 1'b0; step();
    reset = 1'b1; ack = 1'b1; step(); ack = 1'b0;
    check("abort_count", 32'(count), 32'd0);
    check("abort_empty", 32'(empty), 32'd1);
    check("abort_valid", 32'(req_valid), 32'd0);

`ifdef WB_COALESCE_EN
    // Two bytes of one word merge while the head is locked elsewhere
    req_ready = 1'b0;
    pkts = {mk(1'b0, 32'h0, SZ_WORD, 32'h0), mk(1'b1, 32'h500, SZ_WORD, 32'h5555_5555)};
    step(); pkts = '0;
    step();
    pkts = {mk(1'b1, 32'h301, SZ_BYTE, 32'h22), mk(1'b1, 32'h300, SZ_BYTE, 32'h11)};
    #1 check("merge_accept", 32'(accept), 32'h3);
    step(); pkts = '0;
    check("merge_count", 32'(count), 32'd2);
    req_ready = 1'b1;
    step();
    ack = 1'b1; step(); ack = 1'b0;
    step();
    check("merge_addr", req_addr, 32'h300);
    check("merge_be", 32'(req_be), 32'h3);
    check("merge_data", req_data, 32'h0000_2211);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
